// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser states, parity codes and frame helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; refuses pushes when full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full  = (lvl_q == (AW+1)'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q + {{AW{1'b0}}, do_push}
                    - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: run-time frame format, LSB-first serialiser.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import uart_pkg::*;

  state_e           state_q;
  logic [DIV_W-1:0] timer_q, div_q, div_eff;
  logic [7:0]       sh_q;
  logic [2:0]       cnt_q;
  logic [3:0]       nb_q;
  logic [1:0]       par_q;
  logic             stop2_q, acc_q;
  logic             tx_q, tx_d, busy_q, busy_d;

  logic             f_full, f_empty, pop;
  logic [7:0]       f_dout;
  logic             tick, last_bit, par_en, frame_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .din   (s_data),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (fifo_level)
  );

  assign s_ready = !f_full;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  always_comb begin
    div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    tick      = (timer_q == '0);
    last_bit  = ({1'b0, cnt_q} == nb_q - 4'd1);
    par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    frame_end = tick && ((state_q == STOP1 && !stop2_q)
                         || state_q == STOP2);
    pop       = !f_empty && (state_q == IDLE || frame_end);
    busy_d    = (state_q != IDLE) || !f_empty;
    tx_d      = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[0];
      PARITY:  tx_d = acc_q ^ (par_q == PAR_ODD);
      default: tx_d = 1'b1;
    endcase
  end

  // Line output trails the state by one register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= DIV_W'(1);
      sh_q    <= '0;
      cnt_q   <= '0;
      nb_q    <= 4'd8;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      acc_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      if (pop) begin
        sh_q    <= f_dout;
        div_q   <= div_eff;
        timer_q <= div_eff - DIV_W'(1);
        nb_q    <= data_bits(cfg_data_bits);
        par_q   <= cfg_parity;
        stop2_q <= cfg_stop2;
        cnt_q   <= '0;
        acc_q   <= 1'b0;
        state_q <= START;
      end else if (state_q != IDLE) begin
        if (!tick) begin
          timer_q <= timer_q - DIV_W'(1);
        end else begin
          timer_q <= div_q - DIV_W'(1);
          unique case (state_q)
            START: state_q <= DATA;
            DATA: begin
              sh_q  <= sh_q >> 1;
              acc_q <= acc_q ^ sh_q[0];
              cnt_q <= cnt_q + 3'd1;
              if (last_bit) state_q <= par_en ? PARITY : STOP1;
            end
            PARITY:  state_q <= STOP1;
            STOP1:   state_q <= stop2_q ? STOP2 : IDLE;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued expected frames, line monitor.
module tb_uart_tx_fifo;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          div;
    bit          gap0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, tx_o, busy_o;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  exp_t q[$];
  exp_t cur;
  bit   mon_active = 0;
  bit   rogue = 0;
  bit   ok = 1;
  int   bidx = 0, cyc = 0, gap = 0, frame_no = 0;

  uart_tx_fifo #(
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] bits, input int len,
                              input int div, input bit gap0);
    exp_t e;
    e.bits = bits;
    e.len  = len;
    e.div  = div;
    e.gap0 = gap0;
    return e;
  endfunction

  function automatic exp_t f8(input logic [7:0] b, input int div,
                              input bit gap0);
    return mk({6'b0, 1'b1, b, 1'b0}, 10, div, gap0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int div, input int nb, input int par,
                     input bit st2);
    cfg_div       = 16'(div);
    cfg_data_bits = 2'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
  endtask

  task automatic write_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((busy_o || mon_active || q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check({name, "_done_in_time"}, 32'(n < max), 1);
    check({name, "_tx_idle"}, tx_o, 1);
    check({name, "_level"}, fifo_level, 0);
  endtask

  // Line monitor: each bit must hold its value for exactly div clocks.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 0;
      rogue = 0;
      gap = 0;
    end else if (rogue) begin
      if (tx_o === 1'b1) rogue = 0;
    end else begin
      if (!mon_active) begin
        if (tx_o === 1'b0) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: start bit at %0t, none queued",
                     $time);
            rogue = 1;
          end else begin
            cur = q.pop_front();
            frame_no++;
            if (cur.gap0)
              check($sformatf("frame%0d_gap", frame_no), gap, 0);
            mon_active = 1;
            bidx = 0;
            cyc = 0;
            ok = 1;
          end
        end else begin
          gap++;
        end
      end
      if (mon_active) begin
        if (tx_o !== cur.bits[bidx]) ok = 0;
        cyc++;
        if (cyc == cur.div) begin
          check($sformatf("frame%0d_bit%0d", frame_no, bidx), 32'(ok), 1);
          bidx++;
          cyc = 0;
          ok = 1;
          if (bidx == cur.len) begin
            mon_active = 0;
            gap = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lv [6];
    logic       rd [6];
    bit         low_seen;
    lv = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state, checked while reset is held.
    repeat (3) tick();
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    rst = 1'b0;
    repeat (2) tick();

    // 8N1 0x55 at div 4: latency, pattern, busy fall.
    cfg(4, 3, 0, 0);
    q.push_back(mk(16'b1010101010, 10, 4, 0));
    write_byte(8'h55);
    check("lat_k", tx_o, 1);
    tick();
    check("lat_k1", tx_o, 1);
    tick();
    check("lat_k2", tx_o, 0);
    repeat (39) tick();
    check("busy_last_stop", busy_o, 1);
    tick();
    check("busy_fall", busy_o, 0);
    wait_idle("t1", 40);

    // 7E2 0x41 at div 2.
    cfg(2, 2, 1, 1);
    q.push_back(mk(16'b11010000010, 11, 2, 0));
    write_byte(8'h41);
    wait_idle("t2", 100);

    // 8O1 0x00 at div 3.
    cfg(3, 3, 2, 0);
    q.push_back(mk(16'b11000000000, 11, 3, 0));
    write_byte(8'h00);
    wait_idle("t3a", 100);

    // 5N1 0xFF: upper bits dropped.
    cfg(3, 0, 0, 0);
    q.push_back(mk(16'b1111110, 7, 3, 0));
    write_byte(8'hFF);
    wait_idle("t3b", 100);

    // Divisor 0 runs as 1; parity code 3 means none.
    cfg(0, 0, 3, 0);
    q.push_back(mk(16'b1010100, 7, 1, 0));
    write_byte(8'h0A);
    wait_idle("t3c", 50);

    // Six back-to-back writes into a 4-deep FIFO.
    cfg(16, 3, 0, 0);
    for (int i = 0; i < 5; i++)
      q.push_back(f8(8'(8'h11 + i), 16, i != 0));
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'(8'h11 + i);
      tick();
      check($sformatf("t4_level%0d", i), fifo_level, lv[i]);
      check($sformatf("t4_ready%0d", i), s_ready, rd[i]);
    end
    s_valid = 1'b0;
    wait_idle("t4", 1200);

    // Divisor change mid-frame affects only the next frame.
    cfg(4, 3, 0, 0);
    q.push_back(f8(8'hA5, 4, 0));
    q.push_back(f8(8'h3C, 8, 1));
    write_byte(8'hA5);
    write_byte(8'h3C);
    repeat (3) tick();
    cfg_div = 16'd8;
    wait_idle("t5", 400);

    // Reset during DATA of the second of three frames.
    cfg(4, 3, 0, 0);
    q.push_back(f8(8'h01, 4, 0));
    q.push_back(f8(8'h02, 4, 1));
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    repeat (53) tick();
    rst = 1'b1;
    #1;
    check("t6_tx", tx_o, 1);
    check("t6_busy", busy_o, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ready", s_ready, 1);
    repeat (2) tick();
    rst = 1'b0;
    low_seen = 0;
    repeat (60) begin
      tick();
      if (tx_o !== 1'b1 || busy_o !== 1'b0) low_seen = 1;
    end
    check("t6_stays_idle", 32'(low_seen), 0);
    check("t6_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
